ram_arbiter: RTL and testbench

//  Two-requester arbiter for the single-port 4096x16 synchronous RAM (registered q, 1-cycle read latency).

---
 rtl/ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port synchronous RAM
// (registered q, one-cycle read latency). Port 0 is the CPU, port 1 the loader/DMA.
// A requester can hold the RAM across back-to-back cycles with its lock input.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration when
// nobody owns the RAM. Otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              ram_load,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    input  logic [DWIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t            owner_reg, owner_next;
    logic [AWIDTH-1:0] addr_hold_reg, addr_hold_next;
    logic              rpend_reg, rpend_next;
    logic              rsel_reg, rsel_next;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    // last granted port: 0 = P0, 1 = P1
    logic              last_reg, last_next;
`endif

    logic [1:0]        req, we, lock, gnt;
    logic [1:0]        rvalid;
    logic [DWIDTH-1:0] rdata [2];

    assign req  = {req1, req0};
    assign we   = {we1, we0};
    assign lock = {lock1, lock0};
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Arbitration and next-state: owner first, then the idle-time priority rule
    always_comb begin
        gnt            = 2'b00;
        owner_next     = owner_reg;
        addr_hold_next = addr_hold_reg;
        rpend_next     = 1'b0;
        rsel_next      = rsel_reg;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_next      = last_reg;
`endif
        if (n_reset) begin
            unique case (owner_reg)
                OWN_P0: begin
                    if (req[0])      gnt = 2'b01;
                    else if (req[1]) gnt = 2'b10;
                end
                OWN_P1: begin
                    if (req[1])      gnt = 2'b10;
                    else if (req[0]) gnt = 2'b01;
                end
                default: begin
                    if (req == 2'b11) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        gnt = last_reg ? 2'b01 : 2'b10;
`else
                        gnt = 2'b01;
`endif
                    end else begin
                        gnt = req;
                    end
                end
            endcase

            // An owner that stops requesting loses the RAM, so no grant means no owner
            if (gnt[0])      owner_next = lock[0] ? OWN_P0 : OWN_NONE;
            else if (gnt[1]) owner_next = lock[1] ? OWN_P1 : OWN_NONE;
            else             owner_next = OWN_NONE;

            rpend_next = |(gnt & ~we);
            rsel_next  = gnt[1];
            if (gnt[0])      addr_hold_next = addr0;
            else if (gnt[1]) addr_hold_next = addr1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            if (gnt[0])      last_next = 1'b0;
            else if (gnt[1]) last_next = 1'b1;
`endif
        end
    end

    // RAM-side drive: granted port's request, otherwise hold the last address
    always_comb begin
        ram_load = 1'b0;
        ram_addr = n_reset ? addr_hold_reg : '0;
        ram_d    = '0;
        if (gnt[0]) begin
            ram_load = we[0];
            ram_addr = addr0;
            ram_d    = wdata0;
        end else if (gnt[1]) begin
            ram_load = we[1];
            ram_addr = addr1;
            ram_d    = wdata1;
        end
    end

    // State registers; reset also drops any read still waiting to return
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            owner_reg     <= OWN_NONE;
            addr_hold_reg <= '0;
            rpend_reg     <= 1'b0;
            rsel_reg      <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_reg      <= 1'b1;
`endif
        end else begin
            owner_reg     <= owner_next;
            addr_hold_reg <= addr_hold_next;
            rpend_reg     <= rpend_next;
            rsel_reg      <= rsel_next;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_reg      <= last_next;
`endif
        end
    end

    // Read return: RAM q lines up with the cycle after the read grant
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign rvalid[gi] = n_reset && rpend_reg && (rsel_reg == 1'(gi));
            assign rdata[gi]  = rvalid[gi] ? ram_q : '0;
        end
    endgenerate

    assign rvalid0 = rvalid[0];
    assign rvalid1 = rvalid[1];
    assign rdata0  = rdata[0];
    assign rdata1  = rdata[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 4096x16 RAM,
// a shadow memory and a read-return scoreboard queue.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_load;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem    [4096];
    logic [DW-1:0] shadow [4096];

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int            n_assert = 0;
    int            n_fail   = 0;
    bit            have_addr = 0;
    logic [AW-1:0] hold_addr = '0;

    ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .n_reset(n_reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_load(ram_load), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, registered q
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic l0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    // One clock cycle: inputs already driven; check grant, RAM drive and read return
    task automatic step(input string name, input logic eg0, input logic eg1);
        exp_t          e;
        logic [1:0]    ev;
        logic [DW-1:0] ed;
        #2;
        check({name, " gnt0"}, 32'(gnt0), 32'(eg0));
        check({name, " gnt1"}, 32'(gnt1), 32'(eg1));
        check({name, " ram_load"}, 32'(ram_load), 32'((eg0 && we0) || (eg1 && we1)));
        if (eg0) begin
            check({name, " ram_addr"}, 32'(ram_addr), 32'(addr0));
            check({name, " ram_d"}, 32'(ram_d), 32'(wdata0));
        end else if (eg1) begin
            check({name, " ram_addr"}, 32'(ram_addr), 32'(addr1));
            check({name, " ram_d"}, 32'(ram_d), 32'(wdata1));
        end else begin
            check({name, " ram_d"}, 32'(ram_d), 32'd0);
            if (!n_reset)      check({name, " ram_addr"}, 32'(ram_addr), 32'd0);
            else if (have_addr) check({name, " ram_addr hold"}, 32'(ram_addr), 32'(hold_addr));
        end

        ev = 2'b00;
        ed = '0;
        if (!n_reset) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            ev[e.port] = 1'b1;
            ed = e.data;
        end
        check({name, " rvalid0"}, 32'(rvalid0), 32'(ev[0]));
        check({name, " rvalid1"}, 32'(rvalid1), 32'(ev[1]));
        check({name, " rdata0"}, 32'(rdata0), 32'(ev[0] ? ed : '0));
        check({name, " rdata1"}, 32'(rdata1), 32'(ev[1] ? ed : '0));

        if (!n_reset) have_addr = 0;
        if (eg0) begin
            have_addr = 1; hold_addr = addr0;
            if (we0) shadow[addr0] = wdata0;
            else     sb.push_back('{1'b0, shadow[addr0]});
        end else if (eg1) begin
            have_addr = 1; hold_addr = addr1;
            if (we1) shadow[addr1] = wdata1;
            else     sb.push_back('{1'b1, shadow[addr1]});
        end
        $display("%0t %s: gnt0=%b gnt1=%b load=%b addr=%h rvalid0=%b rvalid1=%b rdata0=%h rdata1=%h",
                 $time, name, gnt0, gnt1, ram_load, ram_addr, rvalid0, rvalid1, rdata0, rdata1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rr;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        rr = 1;
`else
        rr = 0;
`endif
        for (int i = 0; i < 4096; i++) shadow[i] = '0;
        n_reset = 1'b0;
        drive(1, 0, 0, 12'h005, 16'h0, 1, 0, 0, 12'h005, 16'h0);
        @(posedge clk);
        #1;

        // Reset with both requesting: everything quiet
        step("rst_a", 0, 0);
        step("rst_b", 0, 0);
        n_reset = 1'b1;

        // P0 write then read of the same address
        drive(1, 1, 0, 12'h001, 16'h1234, 0, 0, 0, 12'h000, 16'h0);
        step("p0_wr", 1, 0);
        drive(1, 0, 0, 12'h001, 16'h0, 0, 0, 0, 12'h000, 16'h0);
        step("p0_rd", 1, 0);
        drive(0, 0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0);
        step("p0_ret", 0, 0);

        // Preload for the wrap-around read burst, via port 1
        drive(0, 0, 0, 12'h000, 16'h0, 1, 1, 0, 12'hFFE, 16'h000A);
        step("pre_a", 0, 1);
        drive(0, 0, 0, 12'h000, 16'h0, 1, 1, 0, 12'hFFF, 16'h000B);
        step("pre_b", 0, 1);
        drive(0, 0, 0, 12'h000, 16'h0, 1, 1, 0, 12'h000, 16'h000C);
        step("pre_c", 0, 1);

        // Contention, no lock: fixed priority P0 x4, round-robin P0,P1,P0,P1
        drive(1, 0, 0, 12'h001, 16'h0, 1, 0, 0, 12'hFFE, 16'h0);
        step("both_1", 1, 0);
        step("both_2", rr ? 1'b0 : 1'b1, rr ? 1'b1 : 1'b0);
        step("both_3", 1, 0);
        step("both_4", rr ? 1'b0 : 1'b1, rr ? 1'b1 : 1'b0);

        // P1 locked burst holds off P0; P0 wins once the lock is released
        drive(0, 0, 0, 12'h001, 16'h0, 1, 0, 1, 12'hFFF, 16'h0);
        step("lock_1", 0, 1);
        drive(1, 0, 0, 12'h001, 16'h0, 1, 0, 1, 12'hFFF, 16'h0);
        step("lock_2", 0, 1);
        drive(1, 0, 0, 12'h001, 16'h0, 1, 0, 0, 12'hFFF, 16'h0);
        step("lock_3", 0, 1);
        step("unlock", 1, 0);

        // P0 takes a lock, then goes idle: ownership must drop
        drive(1, 0, 1, 12'h001, 16'h0, 0, 0, 0, 12'hFFE, 16'h0);
        step("own_p0", 1, 0);
        drive(0, 0, 0, 12'h001, 16'h0, 0, 0, 0, 12'hFFE, 16'h0);
        step("own_idle", 0, 0);
        drive(1, 0, 0, 12'h001, 16'h0, 1, 0, 0, 12'hFFE, 16'h0);
        step("own_drop", rr ? 1'b0 : 1'b1, rr ? 1'b1 : 1'b0);

        // Back-to-back P1 reads across the address wrap
        drive(0, 0, 0, 12'h000, 16'h0, 1, 0, 0, 12'hFFE, 16'h0);
        step("b2b_1", 0, 1);
        addr1 = 12'hFFF;
        step("b2b_2", 0, 1);
        addr1 = 12'h000;
        step("b2b_3", 0, 1);
        drive(0, 0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0);
        step("b2b_ret", 0, 0);

        // Reset while a read is in flight: return suppressed
        drive(1, 0, 0, 12'h001, 16'h0, 0, 0, 0, 12'h000, 16'h0);
        step("rd_pre_rst", 1, 0);
        n_reset = 1'b0;
        drive(0, 0, 0, 12'h001, 16'h0, 0, 0, 0, 12'h000, 16'h0);
        step("rd_in_rst", 0, 0);
        n_reset = 1'b1;
        drive(1, 0, 0, 12'h001, 16'h0, 1, 0, 0, 12'hFFF, 16'h0);
        step("post_rst", 1, 0);
        drive(0, 0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0);
        step("post_ret", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
